rocketcpu_irq_ctrl: RTL
=======================

// Module: rocketcpu_irq_ctrl
// PURPOSE
//  Parametrised Wishbone interrupt controller for the RocketCPU SoC.
//  Collects N_IRQ peripheral interrupt lines and synchronises them.
//  Latches each line per channel as edge- or level-triggered, then masks it.
//  Drives one CPU interrupt line. Also exposes a claim register that returns
//  the lowest-numbered active source and clears it atomically.
// PARAMETERS
//  N_IRQ       6              number of interrupt sources, 1..32
//  BASE_ADDR   32'h0900_0000  word-aligned register base address
//  SYNC_STAGES 2              input synchroniser depth, 0..3; 0 = inputs already synchronous
// PORTS
//  i_wb_clk    in   1      system clock
//  i_wb_rst_n  in   1      reset, asynchronous assert, active-low
//  i_wb_adr    in   32     Wishbone byte address
//  i_wb_dat    in   32     Wishbone write data
//  i_wb_we     in   1      write enable
//  i_wb_cyc    in   1      bus cycle request
//  o_wb_rdt    out  32     read data, registered
//  o_wb_ack    out  1      single-cycle acknowledge
//  i_irq       in   N_IRQ  raw interrupt sources, active-high
//  o_irq       out  1      interrupt request to CPU, registered
// BEHAVIOUR
//  Register map (offset from BASE_ADDR). Bits >= N_IRQ read 0 and ignore writes.
//   0x00 PENDING  R: pending vector.     W: write-1-to-clear, edge channels only.
//   0x04 ENABLE   RW: per-channel mask.
//   0x08 MODE     RW: 1 = rising-edge latched, 0 = level.
//   0x0C SET      W: write-1-to-set pending, edge channels only. R: 0.
//   0x10 CLAIM    R: {26'b0, id+1} of lowest enabled pending channel, 0 if none.
//  Reset (async, i_wb_rst_n=0): all registers, sync flops, o_wb_rdt, o_wb_ack and o_irq go to 0.
//  Bus handshake:
//   - At a clock edge with i_wb_cyc=1 and o_wb_ack=0, o_wb_ack goes to 1 for exactly one cycle.
//   - At that same edge: write commits, o_wb_rdt loads, CLAIM side-effect happens.
//   - i_wb_cyc held high produces an ack every second cycle.
//   - Unmapped addresses: acked, read 0, write ignored.
//  Source path: i_irq passes through SYNC_STAGES flops to give s[i].
//   - Edge channel: pending set when s[i]=1 and s_prev[i]=0.
//   - Level channel: pending[i] = s[i] every cycle (not latched). W1C, SET and claim have no effect.
//  Latency with SYNC_STAGES=2:
//   - i_irq sampled high at edge t -> pending at t+2 -> o_irq at t+3.
//   - o_irq = |(pending & ENABLE), registered.
//  Masked channels still latch pending. Enabling one later raises o_irq one cycle after the write.
//  CLAIM read:
//   - Returns id+1 of the lowest enabled pending channel.
//   - If that channel is edge mode, clears its pending bit at the ack edge.
//  Collisions:
//   - New edge coincident with W1C or claim-clear of the same bit: set wins, edge not lost.
//   - SET and W1C in the same access cannot occur (different addresses).
//  MODE change edge->level: pending follows s[i] from the next cycle.
//  MODE change level->edge: pending clears. s_prev keeps tracking, so no spurious edge.
//  Reset mid-transaction: ack is dropped and any pending write is lost. Master must retry.
// TESTING
//  1. Reset, read 0x00/0x04/0x08/0x10 -> all 0x0, o_irq=0. Each access acks once.
//  2. MODE=0x01, ENABLE=0x01, pulse i_irq[0] for 1 cycle -> o_irq=1 at t+3.
//     PENDING=0x01. Write 0x01 to 0x00 -> o_irq=0 two cycles later.
//  3. MODE=0, ENABLE=0x04, hold i_irq[2]=1 -> CLAIM=0x3 and stays 0x3 after claim.
//     Drop i_irq[2] -> PENDING=0, o_irq=0.
//  4. MODE=0x3F, ENABLE=0x28, SET=0x2A -> CLAIM=0x4, then 0x6, then 0x0.
//     PENDING=0x02, o_irq=0.
//  5. Edge on i_irq[1] timed to land on the CLAIM-clear edge of channel 1 -> PENDING[1] stays 1.
//  6. Assert i_wb_rst_n=0 mid-cycle while o_irq=1 -> o_irq, o_wb_ack and all registers read 0 after release.

Source files
------------

// File: rtl/rocketcpu_irq_ctrl_if.sv
// Wishbone-classic slave bus of the RocketCPU interrupt controller.
// The master drives the request side and the controller returns registered data and ack.
interface rocketcpu_irq_ctrl_if;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
        output o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/rocketcpu_irq_ctrl.sv
// RocketCPU interrupt controller: synchronised sources, per-channel edge/level latching,
// enable masking, W1C/W1S pending access and a lowest-id claim register.
module rocketcpu_irq_ctrl #(
    parameter int unsigned N_IRQ       = 6,
    parameter logic [31:0] BASE_ADDR   = 32'h0900_0000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst_n,
    rocketcpu_irq_ctrl_if.slave  wb,
    input  logic [N_IRQ-1:0]     i_irq,
    output logic                 o_irq
);

    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

    logic [N_IRQ-1:0] s;
    logic [N_IRQ-1:0] s_prev_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] enable_q, enable_d;
    logic [N_IRQ-1:0] mode_q, mode_d;
    logic [31:0]      rdt_q, rdt_d;
    logic             ack_q, ack_d;
    logic             irq_q, irq_d;

    // Input synchroniser; zero stages means the sources are already in this clock domain.
    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = i_irq;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q, sync_d;

        always_comb begin
            sync_d    = sync_q;
            sync_d[0] = i_irq;
            for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
        end

        always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
            if (!i_wb_rst_n) sync_q <= '0;
            else             sync_q <= sync_d;
        end

        assign s = sync_q[SYNC_STAGES-1];
    end

    logic             acc, wr, rd;
    logic             sel_pend, sel_en, sel_mode, sel_set, sel_claim;
    logic [N_IRQ-1:0] wdat;

    assign acc       = wb.i_wb_cyc & ~ack_q;
    assign wr        = acc &  wb.i_wb_we;
    assign rd        = acc & ~wb.i_wb_we;
    assign sel_pend  = (wb.i_wb_adr[31:2] == BASE_W);
    assign sel_en    = (wb.i_wb_adr[31:2] == BASE_W + 30'd1);
    assign sel_mode  = (wb.i_wb_adr[31:2] == BASE_W + 30'd2);
    assign sel_set   = (wb.i_wb_adr[31:2] == BASE_W + 30'd3);
    assign sel_claim = (wb.i_wb_adr[31:2] == BASE_W + 30'd4);
    assign wdat      = wb.i_wb_dat[N_IRQ-1:0];

    logic unused_bus;
    assign unused_bus = ^{wb.i_wb_adr[1:0], wb.i_wb_dat};

    // Lowest-numbered enabled pending channel wins the claim.
    logic [N_IRQ-1:0] active, claim_oh;
    logic [5:0]       claim_val;

    always_comb begin
        active    = pending_q & enable_q;
        claim_oh  = '0;
        claim_val = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_oh    = '0;
                claim_oh[i] = 1'b1;
                claim_val   = 6'(i + 1);
            end
        end
    end

    logic [N_IRQ-1:0] clr, set, edge_det, to_edge;

    always_comb begin
        clr      = '0;
        set      = '0;
        to_edge  = '0;
        edge_det = s & ~s_prev_q;
        if (wr && sel_pend)   clr = wdat;
        if (wr && sel_set)    set = wdat;
        if (rd && sel_claim)  clr = claim_oh;
        if (wr && sel_mode)   to_edge = wdat & ~mode_q;

        enable_d = (wr && sel_en)   ? wdat : enable_q;
        mode_d   = (wr && sel_mode) ? wdat : mode_q;

        pending_d = pending_q;
        for (int i = 0; i < N_IRQ; i++) begin
            if (!mode_q[i])
                pending_d[i] = to_edge[i] ? 1'b0 : s[i];
            else
                // A fresh edge beats a coincident clear so it is never lost.
                pending_d[i] = (pending_q[i] & ~clr[i]) | set[i] | edge_det[i];
        end

        rdt_d = rdt_q;
        if (acc) begin
            rdt_d = '0;
            if      (sel_pend)  rdt_d = 32'(pending_q);
            else if (sel_en)    rdt_d = 32'(enable_q);
            else if (sel_mode)  rdt_d = 32'(mode_q);
            else if (sel_claim) rdt_d = 32'(claim_val);
        end

        ack_d = acc;
        irq_d = |active;
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            s_prev_q  <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            rdt_q     <= '0;
            ack_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            s_prev_q  <= s;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            rdt_q     <= rdt_d;
            ack_q     <= ack_d;
            irq_q     <= irq_d;
        end
    end

    assign wb.o_wb_rdt = rdt_q;
    assign wb.o_wb_ack = ack_q;
    assign o_irq       = irq_q;

endmodule
